// File: rtl/regs_pkg.sv
// Shared types for the picoMIPS register-file write path.
// Both the arbiter and its testbench import this package.
package regs_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int CNT_W  = 4;

   typedef logic        [ADDR_W-1:0] reg_addr_t;
   typedef logic signed [DATA_W-1:0] reg_data_t;

   typedef struct packed {
      logic      valid;
      reg_addr_t addr;
      reg_data_t data;
   } wr_req_t;

   typedef enum logic {
      NORMAL = 1'b0,
      FORCE1 = 1'b1
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_0    = 2'd1,
      GNT_1    = 2'd2
   } grant_e;

endpackage

// File: rtl/starve_counter.sv
// Counts consecutive denied cycles of requester 1.
// Raises hit when the count is about to reach STARVE_MAX.
module starve_counter
   import regs_pkg::*;
#(
   parameter int STARVE_MAX = 3
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             inc,
   input  logic             clr,
   output logic             hit,
   output logic [CNT_W-1:0] cnt
);

   // Compare against the incremented value so FORCE1 is entered on the
   // same edge where the count would reach STARVE_MAX.
   assign hit = inc && ((cnt + CNT_W'(1)) == CNT_W'(STARVE_MAX));

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         cnt <= '0;
      else if (clr || hit)
         cnt <= '0;
      else if (inc)
         cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/regs_wr_arbiter.sv
// Arbitrates the single regs write port between ALU writeback (req0)
// and the I/O load path (req1); registers the winner and flags RAW hazards.
module regs_wr_arbiter
   import regs_pkg::*;
#(
   parameter int DATA_W     = regs_pkg::DATA_W,
   parameter int ADDR_W     = regs_pkg::ADDR_W,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              w,
   output logic [ADDR_W-1:0] Waddr,
   output logic [DATA_W-1:0] Wdata,
   input  logic [ADDR_W-1:0] Raddr1,
   input  logic [ADDR_W-1:0] Raddr2,
   output logic              haz1,
   output logic              haz2,
   output logic [1:0]        grant_id
);

   arb_state_e state, state_d;
   grant_e     grant_q;
   wr_req_t    r0, r1;
   logic       starve_hit;
   logic       starve_inc, starve_clr;

   assign r0 = '{valid: req0_valid, addr: req0_addr, data: req0_data};
   assign r1 = '{valid: req1_valid, addr: req1_addr, data: req1_data};

   assign starve_inc = (state == NORMAL) && r1.valid && !req1_ready;
   assign starve_clr = !r1.valid || req1_ready;

   starve_counter #(
      .STARVE_MAX(STARVE_MAX)
   ) u_starve (
      .clk     (clk),
      .n_reset (n_reset),
      .inc     (starve_inc),
      .clr     (starve_clr),
      .hit     (starve_hit),
      .cnt     ()
   );

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset)
         state <= NORMAL;
      else
         state <= state_d;
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      state_d    = NORMAL;
      case (state)
         NORMAL: begin
            if (r0.valid)
               req0_ready = 1'b1;
            else if (r1.valid)
               req1_ready = 1'b1;
            state_d = starve_hit ? FORCE1 : NORMAL;
         end
         FORCE1: begin
            if (r1.valid)
               req1_ready = 1'b1;
            else if (r0.valid)
               req0_ready = 1'b1;
            state_d = NORMAL;
         end
         default: state_d = NORMAL;
      endcase
   end

   // A granted write to $0 still completes the handshake but never asserts w.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         w       <= 1'b0;
         Waddr   <= '0;
         Wdata   <= '0;
         grant_q <= GNT_NONE;
      end else if (req0_ready) begin
         w       <= (r0.addr != '0);
         Waddr   <= r0.addr;
         Wdata   <= r0.data;
         grant_q <= GNT_0;
      end else if (req1_ready) begin
         w       <= (r1.addr != '0);
         Waddr   <= r1.addr;
         Wdata   <= r1.data;
         grant_q <= GNT_1;
      end else begin
         w       <= 1'b0;
         grant_q <= GNT_NONE;
      end
   end

   assign grant_id = grant_q;
   assign haz1 = w && (Waddr != '0) && (Raddr1 == Waddr);
   assign haz2 = w && (Waddr != '0) && (Raddr2 == Waddr);

endmodule
